// File: rtl/ysyx_23060184_pcgen_pkg.sv
// Shared definitions for the fetch-address unit: next-PC opcodes, FSM states
// and the default reset vector.
package ysyx_23060184_defs;

    localparam int NPC_OP_NEXT   = 0;
    localparam int NPC_OP_JAL    = 1;
    localparam int NPC_OP_JALR   = 2;
    localparam int NPC_OP_BRANCH = 3;
    localparam int NPC_OP_CSR    = 4;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

    typedef enum logic {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } pcgen_state_e;

endpackage

// File: rtl/ysyx_23060184_pcgen_target.sv
// Combinational next-PC target selection plus misaligned-target trap redirect.
// Kept standalone so a branch-predictor checker can reuse the same rules.
module ysyx_23060184_pcgen_target
    import ysyx_23060184_defs::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NPC_OP_LENGTH = 3,
    parameter int INST_BYTES    = 4,
    parameter int ALIGN_CHECK   = 1
) (
    input  logic [NPC_OP_LENGTH-1:0] npc_op,
    input  logic [DATA_WIDTH-1:0]    res_pc,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic                     branch_taken,
    input  logic [DATA_WIDTH-1:0]    csr_read,
    input  logic [DATA_WIDTH-1:0]    mtvec,
    output logic [DATA_WIDTH-1:0]    seq_pc,
    output logic [DATA_WIDTH-1:0]    target,
    output logic [DATA_WIDTH-1:0]    load_pc,
    output logic                     misalign
);

    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(INST_BYTES);

    always_comb begin
        seq_pc = res_pc + INC;
        target = seq_pc;
        case (npc_op)
            NPC_OP_LENGTH'(NPC_OP_JAL):    target = res_pc + imm;
            NPC_OP_LENGTH'(NPC_OP_JALR):   target = {alu_result[DATA_WIDTH-1:1], 1'b0};
            NPC_OP_LENGTH'(NPC_OP_BRANCH): target = branch_taken ? (res_pc + imm) : seq_pc;
            NPC_OP_LENGTH'(NPC_OP_CSR):    target = csr_read;
            default:                       target = seq_pc;
        endcase
        // CSR targets (mtvec/mepc) are trusted and never re-trapped.
        misalign = (ALIGN_CHECK != 0) && (npc_op != NPC_OP_LENGTH'(NPC_OP_CSR))
                   && (target[1:0] != 2'b00);
        load_pc  = misalign ? mtvec : target;
    end

endmodule

// File: rtl/ysyx_23060184_pcgen.sv
// Architectural PC owner: issues PC to the IFU, consumes resolved results,
// handles flush, misaligned-target traps and counts redirects.
module ysyx_23060184_pcgen
    import ysyx_23060184_defs::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    NPC_OP_LENGTH = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR  = DEFAULT_RESET_VECTOR,
    parameter int                    INST_BYTES    = 4,
    parameter int                    ALIGN_CHECK   = 1,
    parameter int                    CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     pc_valid,
    input  logic                     pc_ready,
    output logic [DATA_WIDTH-1:0]    PC,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [NPC_OP_LENGTH-1:0] Npc_op,
    input  logic [DATA_WIDTH-1:0]    ResPC,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    input  logic                     BranchTaken,
    input  logic [DATA_WIDTH-1:0]    CsrRead,
    input  logic [DATA_WIDTH-1:0]    Mtvec,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    FlushPC,
    output logic                     misalign_exc,
    output logic [DATA_WIDTH-1:0]    misalign_addr,
    output logic [CNT_WIDTH-1:0]     redirect_cnt
);

    pcgen_state_e            state_reg, state_next;
    logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic                    exc_reg, exc_next;
    logic [DATA_WIDTH-1:0]   addr_reg, addr_next;

    logic [DATA_WIDTH-1:0]   seq_pc;
    logic [DATA_WIDTH-1:0]   target;
    logic [DATA_WIDTH-1:0]   load_pc;
    logic                    misalign;

    ysyx_23060184_pcgen_target #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NPC_OP_LENGTH(NPC_OP_LENGTH),
        .INST_BYTES   (INST_BYTES),
        .ALIGN_CHECK  (ALIGN_CHECK)
    ) u_target (
        .npc_op      (Npc_op),
        .res_pc      (ResPC),
        .imm         (Imm),
        .alu_result  (ALUResult),
        .branch_taken(BranchTaken),
        .csr_read    (CsrRead),
        .mtvec       (Mtvec),
        .seq_pc      (seq_pc),
        .target      (target),
        .load_pc     (load_pc),
        .misalign    (misalign)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_ISSUE;
            pc_reg    <= RESET_VECTOR;
            cnt_reg   <= '0;
            exc_reg   <= 1'b0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            exc_reg   <= exc_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        exc_next   = 1'b0;
        addr_next  = addr_reg;
        // Flush overrides both handshakes; any result in flight is dropped.
        if (flush) begin
            state_next = S_ISSUE;
            pc_next    = FlushPC;
            cnt_next   = cnt_reg + CNT_WIDTH'(1);
        end else begin
            case (state_reg)
                S_ISSUE: begin
                    if (pc_ready) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (res_valid) begin
                        state_next = S_ISSUE;
                        pc_next    = load_pc;
                        if (load_pc != seq_pc) cnt_next = cnt_reg + CNT_WIDTH'(1);
                        if (misalign) begin
                            exc_next  = 1'b1;
                            addr_next = target;
                        end
                    end
                end
                default: state_next = S_ISSUE;
            endcase
        end
    end

    assign pc_valid      = (state_reg == S_ISSUE);
    assign res_ready     = (state_reg == S_WAIT);
    assign PC            = pc_reg;
    assign misalign_exc  = exc_reg;
    assign misalign_addr = addr_reg;
    assign redirect_cnt  = cnt_reg;

endmodule

// File: tb/tb_ysyx_23060184_pcgen.sv
// Bench for ysyx_23060184_pcgen: directed vector table, corner-case sequences
// and randomized results checked against a next-PC reference model.
module tb_ysyx_23060184_pcgen;

    localparam logic [31:0] RV    = 32'h8000_0000;
    localparam logic [31:0] MTVEC = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pc_valid, pc_ready = 1'b0;
    logic [31:0] PC;
    logic        res_valid = 1'b0, res_ready;
    logic [2:0]  Npc_op = 3'd0;
    logic [31:0] ResPC = '0, Imm = '0, ALUResult = '0, CsrRead = '0;
    logic        BranchTaken = 1'b0;
    logic [31:0] Mtvec = MTVEC;
    logic        flush = 1'b0;
    logic [31:0] FlushPC = '0;
    logic        misalign_exc;
    logic [31:0] misalign_addr;
    logic [31:0] redirect_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] cnt_m = '0;
    logic [31:0] addr_m = '0;

    always #5 clk = ~clk;

    ysyx_23060184_pcgen dut (
        .clk(clk), .resetn(resetn), .pc_valid(pc_valid), .pc_ready(pc_ready), .PC(PC),
        .res_valid(res_valid), .res_ready(res_ready), .Npc_op(Npc_op), .ResPC(ResPC),
        .Imm(Imm), .ALUResult(ALUResult), .BranchTaken(BranchTaken), .CsrRead(CsrRead),
        .Mtvec(Mtvec), .flush(flush), .FlushPC(FlushPC), .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr), .redirect_cnt(redirect_cnt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] respc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        bt;
        logic [31:0] csr;
        logic [31:0] exp_pc;
        logic        exp_exc;
        logic [31:0] exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Next-PC rules written straight from the architectural definition.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] t;
        case (v.op)
            3'd1:    t = v.respc + v.imm;
            3'd2:    t = v.alu - (v.alu % 2);
            3'd3:    t = v.bt ? v.respc + v.imm : v.respc + 32'd4;
            3'd4:    t = v.csr;
            default: t = v.respc + 32'd4;
        endcase
        if (v.op != 3'd4 && (t % 4) != 0) begin
            r.exp_pc = MTVEC; r.exp_exc = 1'b1; r.exp_addr = t;
        end else begin
            r.exp_pc = t; r.exp_exc = 1'b0; r.exp_addr = addr_m;
        end
        return r;
    endfunction

    // Entered at a negedge with the DUT issuing; leaves it issuing again.
    task automatic run_instr(input vec_t v, input string tag);
        chk({tag, ".issue_valid"}, {31'd0, pc_valid}, 32'd1);
        pc_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        pc_ready = 1'b0;
        chk({tag, ".res_ready"}, {31'd0, res_ready}, 32'd1);
        chk({tag, ".wait_valid"}, {31'd0, pc_valid}, 32'd0);
        chk({tag, ".exc_idle"}, {31'd0, misalign_exc}, 32'd0);
        Npc_op = v.op; ResPC = v.respc; Imm = v.imm; ALUResult = v.alu;
        BranchTaken = v.bt; CsrRead = v.csr; res_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        res_valid = 1'b0;
        if (v.exp_pc != v.respc + 32'd4) cnt_m = cnt_m + 32'd1;
        if (v.exp_exc) addr_m = v.exp_addr;
        chk({tag, ".pc"}, PC, v.exp_pc);
        chk({tag, ".pc_valid"}, {31'd0, pc_valid}, 32'd1);
        chk({tag, ".cnt"}, redirect_cnt, cnt_m);
        chk({tag, ".exc"}, {31'd0, misalign_exc}, {31'd0, v.exp_exc});
        chk({tag, ".addr"}, misalign_addr, addr_m);
        $display("%s op=%0d respc=%08h -> pc=%08h exc=%0d cnt=%0d", tag, v.op, v.respc,
                 PC, misalign_exc, redirect_cnt);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t rv;
        logic [31:0] pc_hold;

        tbl[0] = '{3'd0, 32'h8000_0000, 32'h0,        32'h0,        1'b0, 32'h0,        32'h8000_0004, 1'b0, 32'h0};
        tbl[1] = '{3'd3, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0,       1'b1, 32'h0,        32'h8000_0000, 1'b0, 32'h0};
        tbl[2] = '{3'd3, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0,       1'b0, 32'h0,        32'h8000_0014, 1'b0, 32'h0};
        tbl[3] = '{3'd2, 32'h8000_0050, 32'h0,        32'h8000_0103, 1'b0, 32'h0,       MTVEC,         1'b1, 32'h8000_0102};
        tbl[4] = '{3'd1, 32'hFFFF_FFFC, 32'h8,        32'h0,        1'b0, 32'h0,        32'h0000_0004, 1'b0, 32'h8000_0102};
        tbl[5] = '{3'd4, 32'h8000_0060, 32'h0,        32'h0,        1'b0, 32'h8000_0202, 32'h8000_0202, 1'b0, 32'h8000_0102};
        tbl[6] = '{3'd1, 32'h8000_0020, 32'h4,        32'h0,        1'b0, 32'h0,        32'h8000_0024, 1'b0, 32'h8000_0102};
        tbl[7] = '{3'd7, 32'h8000_0030, 32'h40,       32'h0,        1'b1, 32'h0,        32'h8000_0034, 1'b0, 32'h8000_0102};
        tbl[8] = '{3'd3, 32'h8000_0040, 32'h6,        32'h0,        1'b1, 32'h0,        MTVEC,         1'b1, 32'h8000_0046};
        tbl[9] = '{3'd2, 32'h8000_0070, 32'h0,        32'h8000_0201, 1'b0, 32'h0,       32'h8000_0200, 1'b0, 32'h8000_0046};

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reset.pc", PC, RV);
        chk("reset.pc_valid", {31'd0, pc_valid}, 32'd1);
        chk("reset.res_ready", {31'd0, res_ready}, 32'd0);
        chk("reset.cnt", redirect_cnt, 32'd0);
        chk("reset.exc", {31'd0, misalign_exc}, 32'd0);
        chk("reset.addr", misalign_addr, 32'd0);

        for (int i = 0; i < 10; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // IFU stall: result offered while issuing must not be consumed.
        pc_hold = PC;
        Npc_op = 3'd1; ResPC = 32'h8000_0000; Imm = 32'h100; res_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.pc", PC, pc_hold);
            chk("stall.pc_valid", {31'd0, pc_valid}, 32'd1);
            chk("stall.res_ready", {31'd0, res_ready}, 32'd0);
        end
        res_valid = 1'b0;
        $display("stall pc=%08h held for 5 cycles", PC);

        // Flush coinciding with a JAL result handshake.
        pc_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        pc_ready = 1'b0;
        Npc_op = 3'd1; ResPC = 32'h8000_0000; Imm = 32'h100; res_valid = 1'b1;
        flush = 1'b1; FlushPC = 32'h8000_2000;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; res_valid = 1'b0;
        cnt_m = cnt_m + 32'd1;
        chk("flush_jal.pc", PC, 32'h8000_2000);
        chk("flush_jal.pc_valid", {31'd0, pc_valid}, 32'd1);
        chk("flush_jal.cnt", redirect_cnt, cnt_m);
        $display("flush_jal pc=%08h cnt=%0d", PC, redirect_cnt);

        // Flush coinciding with a misaligned JALR: no trap may be raised.
        pc_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        pc_ready = 1'b0;
        Npc_op = 3'd2; ALUResult = 32'h8000_0303; res_valid = 1'b1;
        flush = 1'b1; FlushPC = 32'h8000_3000;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; res_valid = 1'b0;
        cnt_m = cnt_m + 32'd1;
        chk("flush_mis.pc", PC, 32'h8000_3000);
        chk("flush_mis.exc", {31'd0, misalign_exc}, 32'd0);
        chk("flush_mis.addr", misalign_addr, addr_m);
        chk("flush_mis.cnt", redirect_cnt, cnt_m);
        $display("flush_mis pc=%08h exc=%0d", PC, misalign_exc);

        // Flush coinciding with the PC handshake: stay issuing at the new PC.
        pc_ready = 1'b1; flush = 1'b1; FlushPC = 32'h8000_4000;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; pc_ready = 1'b0;
        cnt_m = cnt_m + 32'd1;
        chk("flush_issue.pc", PC, 32'h8000_4000);
        chk("flush_issue.pc_valid", {31'd0, pc_valid}, 32'd1);
        chk("flush_issue.res_ready", {31'd0, res_ready}, 32'd0);
        chk("flush_issue.cnt", redirect_cnt, cnt_m);
        $display("flush_issue pc=%08h cnt=%0d", PC, redirect_cnt);

        for (int i = 0; i < 200; i++) begin
            rv.op    = 3'($urandom_range(0, 7));
            rv.respc = $urandom & 32'hFFFF_FFFC;
            rv.imm   = $urandom & 32'hFFFF_FFFE;
            rv.alu   = $urandom;
            rv.bt    = 1'($urandom_range(0, 1));
            rv.csr   = $urandom;
            rv.exp_pc = '0; rv.exp_exc = 1'b0; rv.exp_addr = '0;
            run_instr(model(rv), $sformatf("rand%0d", i));
        end

        // Asynchronous reset while waiting on a result.
        pc_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        pc_ready = 1'b0;
        Npc_op = 3'd1; ResPC = 32'h8000_0000; Imm = 32'h200; res_valid = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("areset.pc", PC, RV);
        chk("areset.pc_valid", {31'd0, pc_valid}, 32'd1);
        chk("areset.cnt", redirect_cnt, 32'd0);
        chk("areset.addr", misalign_addr, 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        resetn = 1'b1;
        cnt_m = '0; addr_m = '0;
        #1;
        chk("areset.pc_after", PC, RV);
        $display("areset pc=%08h cnt=%0d", PC, redirect_cnt);
        @(negedge clk);
        run_instr(tbl[0], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
